// File: rtl/mos_job_arbiter.sv
// mos_job_arbiter: round-robin sharing of one MOS systolic matmul engine
// between two clients. A granted client's 2*N*N input words are streamed
// into the engine as one contiguous burst; the 2N-1 anti-diagonal result
// words are returned to that client, tagged with its id.
module mos_job_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_data,
  output logic [1:0]  req_ready,
  output logic        eng_in_valid,
  output logic        eng_matrix_size,
  output logic [15:0] eng_in_data,
  input  logic        eng_out_valid,
  input  logic [39:0] eng_out_data,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [39:0] resp_data,
  output logic        resp_last,
  output logic        busy,
  output logic [1:0]  err_gap,
  output logic        err_timeout
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]    state;
  logic          gnt;      // granted client
  logic          sz;       // latched matrix size of the current job
  logic          rr;       // client with priority at the next grant
  logic [7:0]    wcnt;     // input words still to take
  logic [3:0]    rcnt;     // result words already returned
  logic [TW-1:0] tcnt;     // cycles spent waiting for the first result

  logic          pick;
  logic          word_ok;
  logic [15:0]   word;
  logic [3:0]    rtot;

  // Grant choice, granted client's word, and the one-hot take strobe.
  always_comb begin
    pick      = req_valid[rr] ? rr : ~rr;
    word_ok   = req_valid[gnt];
    word      = gnt ? req_data[31:16] : req_data[15:0];
    rtot      = sz ? 4'd15 : 4'd7;
    req_ready = '0;
    if (state == LOAD) req_ready[gnt] = 1'b1;
  end

  assign busy = (state != IDLE);

  // Job sequencing, registered engine drive and registered response path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      gnt             <= 1'b0;
      sz              <= 1'b0;
      rr              <= 1'b0;
      wcnt            <= '0;
      rcnt            <= '0;
      tcnt            <= '0;
      eng_in_valid    <= 1'b0;
      eng_matrix_size <= 1'b0;
      eng_in_data     <= '0;
      resp_valid      <= 1'b0;
      resp_id         <= 1'b0;
      resp_data       <= '0;
      resp_last       <= 1'b0;
      err_gap         <= '0;
      err_timeout     <= 1'b0;
    end else begin
      eng_in_valid <= 1'b0;
      eng_in_data  <= '0;
      resp_valid   <= 1'b0;
      resp_last    <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            gnt             <= pick;
            rr              <= ~pick;
            sz              <= req_size[pick];
            eng_matrix_size <= req_size[pick];
            wcnt            <= req_size[pick] ? 8'd128 : 8'd32;
            state           <= LOAD;
          end
        end
        LOAD: begin
          // A missing word still consumes its slot so the burst never stretches.
          eng_in_valid <= 1'b1;
          eng_in_data  <= word_ok ? word : '0;
          if (!word_ok) err_gap[gnt] <= 1'b1;
          wcnt <= wcnt - 8'd1;
          if (wcnt == 8'd1) begin
            tcnt  <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (eng_out_valid) begin
            resp_valid <= 1'b1;
            resp_id    <= gnt;
            resp_data  <= eng_out_data;
            rcnt       <= 4'd1;
            state      <= DRAIN;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= GAP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DRAIN: begin
          if (eng_out_valid) begin
            resp_valid <= 1'b1;
            resp_id    <= gnt;
            resp_data  <= eng_out_data;
            rcnt       <= rcnt + 4'd1;
            if (rcnt + 4'd1 == rtot) begin
              resp_last <= 1'b1;
              state     <= GAP;
            end
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mos_job_arbiter.sv
// Testbench for mos_job_arbiter: client drivers, a behavioural engine model
// and a scoreboard built from the stream each client was asked to send.
module tb_mos_job_arbiter;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_ready;
  logic        eng_in_valid, eng_matrix_size;
  logic [15:0] eng_in_data;
  logic        eng_out_valid = 1'b0;
  logic [39:0] eng_out_data = '0;
  logic        resp_valid, resp_id, resp_last, busy, err_timeout;
  logic [39:0] resp_data;
  logic [1:0]  err_gap;
  logic [66:0] outs;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mos_job_arbiter #(.TIMEOUT(TIMEOUT), .TW(7)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_size(req_size),
    .req_data(req_data), .req_ready(req_ready), .eng_in_valid(eng_in_valid),
    .eng_matrix_size(eng_matrix_size), .eng_in_data(eng_in_data),
    .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_last(resp_last), .busy(busy), .err_gap(err_gap),
    .err_timeout(err_timeout)
  );

  assign outs = {req_ready, eng_in_valid, eng_matrix_size, eng_in_data, resp_valid,
                 resp_id, resp_data, resp_last, busy, err_gap, err_timeout};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- client drivers ----------------
  logic [15:0] cq0[$], cq1[$];
  int idx0 = 0, idx1 = 0, enq0 = 0, enq1 = 0;
  int dlo0 = -1, dhi0 = -1, dlo1 = -1, dhi1 = -1;

  always @(negedge clk) begin
    if (cq0.size() > 0) begin
      req_valid[0]    = !(idx0 >= dlo0 && idx0 <= dhi0);
      req_data[15:0]  = cq0[0];
      if (req_ready[0]) begin void'(cq0.pop_front()); idx0++; end
    end else begin
      req_valid[0] = 1'b0; req_data[15:0] = '0;
    end
    if (cq1.size() > 0) begin
      req_valid[1]    = !(idx1 >= dlo1 && idx1 <= dhi1);
      req_data[31:16] = cq1[0];
      if (req_ready[1]) begin void'(cq1.pop_front()); idx1++; end
    end else begin
      req_valid[1] = 1'b0; req_data[31:16] = '0;
    end
  end

  // ---------------- engine model ----------------
  function automatic longint adiag(input logic [15:0] w[$], input int n, input int d);
    longint s = 0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        if (i + j == d)
          for (int k = 0; k < n; k++)
            if (n*n + k*n + j < w.size())
              s += longint'($signed(w[i*n+k])) * longint'($signed(w[n*n+k*n+j]));
    return s;
  endfunction

  logic [15:0] capq[$], allcap[$];
  logic [39:0] outq[$];
  int blen[$], bstart[$], csize[$];
  int dly = 0;
  bit eng_mute = 0, hole_en = 0, holed = 0;
  logic cap_size = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      capq.delete(); outq.delete(); dly = 0;
      eng_out_valid = 1'b0; eng_out_data = '0;
    end else begin
      if (eng_in_valid) begin
        if (capq.size() == 0) begin
          cap_size = eng_matrix_size; bstart.push_back(cyc); csize.push_back(int'(eng_matrix_size));
        end else if (eng_matrix_size !== cap_size) begin
          csize.push_back(9);
        end
        capq.push_back(eng_in_data);
      end else if (capq.size() > 0) begin
        int n;
        n = cap_size ? 8 : 4;
        blen.push_back(capq.size());
        foreach (capq[i]) allcap.push_back(capq[i]);
        if (!eng_mute)
          for (int d = 0; d < 2*n-1; d++) outq.push_back(40'(adiag(capq, n, d)));
        capq.delete(); dly = 3; holed = 0;
      end
      eng_out_valid = 1'b0;
      if (dly > 0) dly--;
      else if (outq.size() > 0) begin
        if (hole_en && outq.size() == 4 && !holed) holed = 1;
        else begin eng_out_valid = 1'b1; eng_out_data = outq.pop_front(); end
      end
    end
  end

  // ---------------- monitor ----------------
  int glog[$], gstart[$], rlen[$], lastq[$];
  logic [41:0] rq[$];
  int ovl = 0, rcount = 0, last_ready_cyc = 0, busy_fall = -1, to_cyc = -1;
  logic [1:0] prev_ready = '0;
  logic prev_busy = 1'b0, prev_to = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ready == 2'b11) ovl++;
      if (req_ready != 2'b00) begin
        if (prev_ready == 2'b00) begin
          gstart.push_back(cyc); glog.push_back(int'(req_ready[1])); rcount = 0;
        end
        rcount++; last_ready_cyc = cyc;
      end else if (prev_ready != 2'b00) rlen.push_back(rcount);
      prev_ready = req_ready;
      if (resp_valid) begin
        rq.push_back({resp_id, resp_last, resp_data});
        if (resp_last) lastq.push_back(cyc);
      end
      if (!busy && prev_busy) busy_fall = cyc;
      prev_busy = busy;
      if (err_timeout && !prev_to) to_cyc = cyc;
      prev_to = err_timeout;
    end else begin
      prev_ready = '0; prev_busy = 1'b0; prev_to = 1'b0;
    end
  end

  // ---------------- expectations ----------------
  logic [15:0] exp_fwd[$];
  logic [41:0] exp_rq[$];
  int exp_glog[$], exp_rlen[$], exp_sz[$];

  function automatic int diff16(input logic [15:0] a[$], input logic [15:0] b[$]);
    int m = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) m++;
    return m;
  endfunction
  function automatic int diff42(input logic [41:0] a[$], input logic [41:0] b[$]);
    int m = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) m++;
    return m;
  endfunction
  function automatic int diffi(input int a[$], input int b[$]);
    int m = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) m++;
    return m;
  endfunction

  // Queue one job on client c, in expected grant order.
  task automatic add_job(input int c, input int size, input bit ident, input bit expect_resp);
    int n, w;
    logic [15:0] v;
    logic [15:0] fw[$];
    n = (size != 0) ? 8 : 4;
    w = 2*n*n;
    for (int k = 0; k < w; k++) begin
      if (ident) v = (k < n*n) ? (((k / n) == (k % n)) ? 16'd1 : 16'd0) : 16'd2;
      else v = 16'($urandom);
      if (c == 0) begin
        cq0.push_back(v); if (enq0 >= dlo0 && enq0 <= dhi0) v = '0; enq0++;
      end else begin
        cq1.push_back(v); if (enq1 >= dlo1 && enq1 <= dhi1) v = '0; enq1++;
      end
      fw.push_back(v); exp_fwd.push_back(v);
    end
    exp_glog.push_back(c); exp_rlen.push_back(w); exp_sz.push_back(size);
    if (expect_resp)
      for (int d = 0; d < 2*n-1; d++)
        exp_rq.push_back({c[0], (d == 2*n-2), 40'(adiag(fw, n, d))});
    req_size[c] = size[0];
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clear_logs();
    glog.delete(); gstart.delete(); rlen.delete(); lastq.delete(); rq.delete();
    blen.delete(); bstart.delete(); csize.delete(); allcap.delete();
    exp_fwd.delete(); exp_rq.delete(); exp_glog.delete(); exp_rlen.delete(); exp_sz.delete();
    ovl = 0; busy_fall = -1; to_cyc = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cq0.delete(); cq1.delete();
    idx0 = 0; idx1 = 0; enq0 = 0; enq1 = 0;
    dlo0 = -1; dhi0 = -1; dlo1 = -1; dhi1 = -1;
    eng_mute = 0; hole_en = 0; req_size = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    clear_logs();
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int t = 0; t < 3000; t++) begin
      step();
      if (cq0.size() == 0 && cq1.size() == 0 && capq.size() == 0 &&
          outq.size() == 0 && dly == 0 && !busy) begin ok = 1; break; end
    end
    step(); step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; #1;
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs: got %h need 0", outs); end
    do_reset();
    step(); step();
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL idle_outputs: got %h need 0", outs); end
  endtask

  task automatic test_single();
    bit ok;
    int m;
    int k7[7] = '{2, 4, 6, 8, 6, 4, 2};
    do_reset();
    add_job(0, 0, 1, 1);
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_done: got timeout need done"); end
    checks++; m = diffi(glog, exp_glog);
    if (m != 0) begin failures++; $display("FAIL single_grant: mismatches=%0d need 0", m); end
    checks++; m = diffi(rlen, exp_rlen);
    if (m != 0) begin failures++; $display("FAIL single_ready_len: mismatches=%0d need 0", m); end
    checks++; m = diffi(blen, exp_rlen);
    if (m != 0) begin failures++; $display("FAIL single_burst_len: mismatches=%0d need 0", m); end
    checks++;
    if (bstart.size() != 1 || gstart.size() != 1 || bstart[0] != gstart[0] + 1) begin
      failures++; $display("FAIL single_burst_start: got %0d burst(s) need burst 1 cycle after ready", bstart.size());
    end
    checks++; m = diff16(allcap, exp_fwd);
    if (m != 0) begin failures++; $display("FAIL single_fwd: mismatches=%0d need 0", m); end
    checks++; m = diff42(rq, exp_rq);
    if (m != 0) begin failures++; $display("FAIL single_resp: mismatches=%0d need 0", m); end
    checks++; m = (rq.size() == 7) ? 0 : 1;
    for (int i = 0; i < 7 && i < rq.size(); i++)
      if (rq[i] !== {1'b0, (i == 6), 40'(k7[i])}) m++;
    if (m != 0) begin failures++; $display("FAIL single_known_values: mismatches=%0d need 0", m); end
    checks++;
    if (lastq.size() != 1 || busy_fall != lastq[0] + 1) begin
      failures++; $display("FAIL single_busy_drop: got cycle %0d need last+1", busy_fall);
    end
    checks++; m = diffi(csize, exp_sz);
    if (m != 0) begin failures++; $display("FAIL single_size: mismatches=%0d need 0", m); end
  endtask

  task automatic test_both();
    bit ok;
    int m;
    do_reset();
    add_job(0, 0, 0, 1);
    add_job(1, 1, 0, 1);
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL both_done: got timeout need done"); end
    checks++; m = diffi(glog, exp_glog);
    if (m != 0) begin failures++; $display("FAIL both_grant: mismatches=%0d need 0", m); end
    checks++; m = diffi(rlen, exp_rlen);
    if (m != 0) begin failures++; $display("FAIL both_ready_len: mismatches=%0d need 0", m); end
    checks++;
    if (ovl != 0) begin failures++; $display("FAIL both_overlap: got %0d need 0", ovl); end
    checks++; m = diff16(allcap, exp_fwd);
    if (m != 0) begin failures++; $display("FAIL both_fwd: mismatches=%0d need 0", m); end
    checks++; m = diff42(rq, exp_rq);
    if (m != 0) begin failures++; $display("FAIL both_resp: mismatches=%0d need 0", m); end
    checks++; m = diffi(csize, exp_sz);
    if (m != 0) begin failures++; $display("FAIL both_size: mismatches=%0d need 0", m); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int m;
    do_reset();
    hole_en = 1;
    add_job(0, 0, 0, 1);
    add_job(1, 1, 0, 1);
    add_job(0, 0, 0, 1);
    add_job(1, 1, 0, 1);
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_done: got timeout need done"); end
    checks++; m = diffi(glog, exp_glog);
    if (m != 0) begin failures++; $display("FAIL b2b_grant_order: mismatches=%0d need 0", m); end
    checks++; m = diffi(rlen, exp_rlen);
    if (m != 0) begin failures++; $display("FAIL b2b_ready_len: mismatches=%0d need 0", m); end
    checks++; m = diff16(allcap, exp_fwd);
    if (m != 0) begin failures++; $display("FAIL b2b_fwd: mismatches=%0d need 0", m); end
    checks++; m = diff42(rq, exp_rq);
    if (m != 0) begin failures++; $display("FAIL b2b_resp: mismatches=%0d need 0", m); end
    checks++; m = (gstart.size() == 4 && lastq.size() == 4) ? 0 : 1;
    for (int k = 0; k < 3 && k + 1 < gstart.size() && k < lastq.size(); k++)
      if (gstart[k+1] != lastq[k] + 2) m++;
    if (m != 0) begin failures++; $display("FAIL b2b_gap_spacing: mismatches=%0d need 0", m); end
  endtask

  task automatic test_gap();
    bit ok;
    int m;
    do_reset();
    dlo1 = 10; dhi1 = 12;
    add_job(1, 0, 0, 1);
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL gap_done: got timeout need done"); end
    checks++; m = diffi(blen, exp_rlen);
    if (m != 0) begin failures++; $display("FAIL gap_burst_len: mismatches=%0d need 0", m); end
    checks++; m = diff16(allcap, exp_fwd);
    if (m != 0) begin failures++; $display("FAIL gap_fwd: mismatches=%0d need 0", m); end
    checks++;
    if (err_gap !== 2'b10) begin failures++; $display("FAIL gap_flag: got %b need 10", err_gap); end
    checks++; m = diff42(rq, exp_rq);
    if (m != 0) begin failures++; $display("FAIL gap_resp: mismatches=%0d need 0", m); end
  endtask

  task automatic test_timeout();
    bit ok;
    int m;
    do_reset();
    eng_mute = 1;
    add_job(0, 0, 0, 0);
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL to_done: got timeout need done"); end
    checks++;
    if (to_cyc != last_ready_cyc + 1 + TIMEOUT) begin
      failures++; $display("FAIL to_latency: got %0d need %0d", to_cyc - last_ready_cyc - 1, TIMEOUT);
    end
    checks++;
    if (rq.size() != 0) begin failures++; $display("FAIL to_no_resp: got %0d need 0", rq.size()); end
    checks++;
    if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_flag: got %b need 1", err_timeout); end
    eng_mute = 0;
    clear_logs();
    add_job(1, 1, 0, 1);
    wait_done(ok);
    checks++; m = diffi(glog, exp_glog);
    if (!ok || m != 0) begin failures++; $display("FAIL to_next_grant: mismatches=%0d need 0", m); end
    checks++; m = diff42(rq, exp_rq);
    if (m != 0) begin failures++; $display("FAIL to_next_resp: mismatches=%0d need 0", m); end
    checks++;
    if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky: got %b need 1", err_timeout); end
  endtask

  task automatic test_async_reset();
    bit ok;
    int m;
    do_reset();
    add_job(0, 1, 0, 1);
    for (int t = 0; t < 500 && idx0 < 50; t++) step();
    checks++;
    if (!(busy === 1'b1 && eng_in_valid === 1'b1 && idx0 == 50)) begin
      failures++; $display("FAIL ar_mid_load: got word %0d busy %b need word 50 busy 1", idx0, busy);
    end
    rst_n = 1'b0; #1;
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL ar_outputs: got %h need 0", outs); end
    do_reset();
    add_job(0, 0, 0, 1);
    wait_done(ok);
    checks++; m = diffi(blen, exp_rlen);
    if (!ok || m != 0) begin failures++; $display("FAIL ar_fresh_burst: mismatches=%0d need 0", m); end
    checks++; m = diff16(allcap, exp_fwd);
    if (m != 0) begin failures++; $display("FAIL ar_fwd: mismatches=%0d need 0", m); end
    checks++; m = diff42(rq, exp_rq);
    if (m != 0) begin failures++; $display("FAIL ar_resp: mismatches=%0d need 0", m); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_back_to_back();
    test_gap();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish need finish");
    $fatal(1, "watchdog expired");
  end

endmodule
